// File: rtl/mem_seq_ctrl.sv
// mem_seq_ctrl
// Sequences row-activate / column-write / column-read strobes over a frame of
// ROWS x COLS locations. MODE 0 writes every row and then reads every row;
// MODE 1 writes one row and reads it back before moving to the next row.
//
// Ports
//   clk         : sole clock, rising edge
//   rst         : synchronous, active-high reset
//   en          : start request, only looked at while idle
//   stall       : freeze request; the cycle that follows a stalled edge issues
//                 no strobe and does not advance the sequence
//   act/rd/wr   : row activate, column read, column write strobes
//   addr_row_w  : current write row      addr_row_r : current read row
//   addr_col_w  : current write column   addr_col_r : current read column
//   busy        : frame in progress (every state except IDLE)
//   done        : one-cycle frame-complete pulse
module mem_seq_ctrl #(
   parameter int ROW_W = 8,
   parameter int COL_W = 8,
   parameter int ROWS  = 2,
   parameter int COLS  = 4,
   parameter int T_RCD = 1,
   parameter int MODE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             stall,
   output logic             act,
   output logic             rd,
   output logic             wr,
   output logic [ROW_W-1:0] addr_row_w,
   output logic [ROW_W-1:0] addr_row_r,
   output logic [COL_W-1:0] addr_col_w,
   output logic [COL_W-1:0] addr_col_r,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] ACT_W  = 3'd1;
   localparam logic [2:0] WAIT_W = 3'd2;
   localparam logic [2:0] WRITE  = 3'd3;
   localparam logic [2:0] ACT_R  = 3'd4;
   localparam logic [2:0] WAIT_R = 3'd5;
   localparam logic [2:0] READ   = 3'd6;
   localparam logic [2:0] DONE   = 3'd7;

   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
   localparam logic [3:0]       WAIT_LAST = (T_RCD == 0) ? 4'd0 : 4'(T_RCD - 1);

   logic [2:0]       state_reg, state_next;
   logic [ROW_W-1:0] row_w_reg, row_w_next;
   logic [ROW_W-1:0] row_r_reg, row_r_next;
   logic [COL_W-1:0] col_w_reg, col_w_next;
   logic [COL_W-1:0] col_r_reg, col_r_next;
   logic [3:0]       wait_reg, wait_next;
   // Set when stall was sampled on the edge that started the current cycle.
   // Keeping stall behind a register keeps every output free of any
   // combinational path from the inputs.
   logic             stalled_reg, stalled_next;
   logic             advance;

   assign advance = !stalled_reg;

   always_comb begin
      state_next = state_reg;
      row_w_next = row_w_reg;
      row_r_next = row_r_reg;
      col_w_next = col_w_reg;
      col_r_next = col_r_reg;
      wait_next  = wait_reg;
      case (state_reg)
         IDLE: begin
            if (en) state_next = ACT_W;
         end
         ACT_W, ACT_R: begin
            if (advance) begin
               wait_next = 4'd0;
               if (state_reg == ACT_W) state_next = (T_RCD == 0) ? WRITE : WAIT_W;
               else                    state_next = (T_RCD == 0) ? READ  : WAIT_R;
            end
         end
         WAIT_W, WAIT_R: begin
            if (advance) begin
               if (wait_reg == WAIT_LAST) state_next = (state_reg == WAIT_W) ? WRITE : READ;
               else                       wait_next  = wait_reg + 4'd1;
            end
         end
         WRITE: begin
            if (advance) begin
               if (col_w_reg == COL_LAST) begin
                  col_w_next = '0;
                  if (MODE == 0) begin
                     if (row_w_reg != ROW_LAST) begin
                        row_w_next = row_w_reg + 1'b1;
                        state_next = ACT_W;
                     end else begin
                        row_r_next = '0;
                        state_next = ACT_R;
                     end
                  end else begin
                     row_r_next = row_w_reg;
                     state_next = ACT_R;
                  end
               end else begin
                  col_w_next = col_w_reg + 1'b1;
               end
            end
         end
         READ: begin
            if (advance) begin
               if (col_r_reg == COL_LAST) begin
                  col_r_next = '0;
                  if (row_r_reg != ROW_LAST) begin
                     row_r_next = row_r_reg + 1'b1;
                     if (MODE == 0) begin
                        state_next = ACT_R;
                     end else begin
                        row_w_next = row_w_reg + 1'b1;
                        state_next = ACT_W;
                     end
                  end else begin
                     // Frame complete: counters are cleared as DONE is entered
                     // so the next frame always starts from row 0, column 0.
                     row_w_next = '0;
                     row_r_next = '0;
                     state_next = DONE;
                  end
               end else begin
                  col_r_next = col_r_reg + 1'b1;
               end
            end
         end
         DONE: begin
            row_w_next = '0;
            row_r_next = '0;
            col_w_next = '0;
            col_r_next = '0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Stall only freezes the working states; IDLE and DONE ignore it.
      stalled_next = stall && (state_next != IDLE) && (state_next != DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         row_w_reg   <= '0;
         row_r_reg   <= '0;
         col_w_reg   <= '0;
         col_r_reg   <= '0;
         wait_reg    <= '0;
         stalled_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         row_w_reg   <= row_w_next;
         row_r_reg   <= row_r_next;
         col_w_reg   <= col_w_next;
         col_r_reg   <= col_r_next;
         wait_reg    <= wait_next;
         stalled_reg <= stalled_next;
      end
   end

   assign act        = ((state_reg == ACT_W) || (state_reg == ACT_R)) && !stalled_reg;
   assign wr         = (state_reg == WRITE) && !stalled_reg;
   assign rd         = (state_reg == READ) && !stalled_reg;
   assign busy       = (state_reg != IDLE);
   assign done       = (state_reg == DONE);
   assign addr_row_w = row_w_reg;
   assign addr_row_r = row_r_reg;
   assign addr_col_w = col_w_reg;
   assign addr_col_r = col_r_reg;

endmodule
